// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher feeding a first-word-fall-through queue.
// Define PREFETCH_STATS_EN to add saturating fetch/flush statistics counters.
module instr_prefetch_queue #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]           stat_fetch_cnt,
  output logic [15:0]           stat_flush_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_inflight;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];

  logic w_run;
  logic w_room;
  logic w_clear;
  logic w_enq;
  logic w_pop;
  logic w_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Redirect wins over everything, including start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        S_FLUSH: w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The in-flight word is reserved a slot so the queue can never overflow.
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_room     = (int'(r_count) + int'(r_inflight)) < DEPTH;
    ifu_rd_req = w_run && w_room;
  end

  assign w_clear = redirect || (r_state == S_FLUSH);
  assign w_valid = (r_count != '0);
  assign w_enq   = r_inflight && w_run && !redirect;
  assign w_pop   = w_valid && instr_ready && !w_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= ifu_rd_req;
      if (ifu_rd_req) r_req_pc <= r_fetch_pc;
      if (redirect)                       r_fetch_pc <= redirect_pc;
      else if (r_state == S_IDLE && start) r_fetch_pc <= base_addr;
      else if (ifu_rd_req)                r_fetch_pc <= r_fetch_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_data[r_wr_ptr] <= ifu_rd_data;
      r_mem_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  assign ifu_rd_addr = r_fetch_pc;
  assign instr_valid = w_valid;
  assign instr_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign instr_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (ifu_rd_req && r_fetch_cnt != 16'hFFFF) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (redirect && r_flush_cnt != 16'hFFFF)   r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stat_fetch_cnt = r_fetch_cnt;
  assign stat_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: table-driven fetch runs plus redirect/reset/stats sequences.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data = 12'hBAD;
  logic        instr_valid;
  logic [11:0] instr_data;
  logic [11:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetch_cnt;
  logic [15:0] stat_flush_cnt;
`endif

  instr_prefetch_queue #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifu_rd_req  (ifu_rd_req),
    .ifu_rd_addr (ifu_rd_addr),
    .ifu_rd_data (ifu_rd_data),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] base;
    logic        ready;
    int          ncyc;
    int          exp_reqs;
    logic        exp_valid;
    logic [11:0] exp_head;
    int          exp_first;
    logic        exp_req_end;
  } vec_t;

  typedef struct {
    logic [11:0] pc;
    logic [11:0] data;
  } sb_t;

  vec_t        vecs[5];
  sb_t         sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_req   = 0;
  logic [11:0] exp_addr = '0;

  function automatic logic [11:0] memf(input logic [11:0] a);
    return a ^ 12'hA5C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers the request seen this cycle during the next cycle.
  task automatic step();
    logic        r;
    logic [11:0] a;
    r = ifu_rd_req;
    a = ifu_rd_addr;
    @(posedge clk);
    #1;
    ifu_rd_data = r ? memf(a) : 12'hBAD;
  endtask

  task automatic observe();
    sb_t e;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 32'(instr_pc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("pop_pc", 32'(instr_pc), 32'(e.pc));
        check("pop_data", 32'(instr_data), 32'(e.data));
      end
    end
    if (ifu_rd_req) begin
      check("req_addr", 32'(ifu_rd_addr), 32'(exp_addr));
      e.pc   = exp_addr;
      e.data = memf(exp_addr);
      sb.push_back(e);
      exp_addr = exp_addr + 12'd1;
      n_req++;
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    start       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    base_addr   = '0;
    redirect_pc = '0;
    ifu_rd_data = 12'hBAD;
    sb.delete();
    n_req = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic do_start(input logic [11:0] base);
    base_addr = base;
    start     = 1'b1;
    exp_addr  = base;
    step();
    start     = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},   32'(ifu_rd_req),  32'd0);
    check({tag, "_addr"},  32'(ifu_rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_data"},  32'(instr_data),  32'd0);
    check({tag, "_pc"},    32'(instr_pc),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int first;

    vecs[0] = '{12'h080, 1'b1, 8, 8, 1'b1, 12'h086, 3, 1'b1};
    vecs[1] = '{12'h080, 1'b0, 8, 4, 1'b1, 12'h080, 3, 1'b0};
    vecs[2] = '{12'hFFE, 1'b1, 6, 6, 1'b1, 12'h002, 3, 1'b1};
    vecs[3] = '{12'h123, 1'b0, 3, 3, 1'b1, 12'h123, 3, 1'b1};
    vecs[4] = '{12'h7FF, 1'b1, 2, 2, 1'b1, 12'h7FF, 3, 1'b1};

    // Reset state
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    do_reset();
    instr_ready = 1'b1;
    repeat (3) begin
      check("idle_no_req", 32'(ifu_rd_req), 32'd0);
      step();
    end

    // Table-driven fetch runs
    for (int v = 0; v < 5; v++) begin
      do_reset();
      instr_ready = vecs[v].ready;
      do_start(vecs[v].base);
      first = -1;
      for (int c = 1; c <= vecs[v].ncyc; c++) begin
        if (instr_valid && first < 0) first = c;
        observe();
        step();
      end
      if (instr_valid && first < 0) first = vecs[v].ncyc + 1;
      check($sformatf("v%0d_reqs", v),     32'(n_req),       32'(vecs[v].exp_reqs));
      check($sformatf("v%0d_valid", v),    32'(instr_valid), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d_head", v),     32'(instr_pc),    32'(vecs[v].exp_head));
      check($sformatf("v%0d_first", v),    32'(first),       32'(vecs[v].exp_first));
      check($sformatf("v%0d_req_end", v),  32'(ifu_rd_req),  32'(vecs[v].exp_req_end));
    end

    // Redirect with three queued words and one returning in flight
    do_reset();
    do_start(12'h080);
    repeat (4) begin
      observe();
      step();
    end
    check("full_no_req", 32'(ifu_rd_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 12'h300;
    observe();
    step();
    redirect    = 1'b0;
    redirect_pc = 12'h555;
    sb.delete();
    exp_addr    = 12'h300;
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_req",   32'(ifu_rd_req),  32'd0);
    instr_ready = 1'b1;
    step();
    check("redir_req",  32'(ifu_rd_req),  32'd1);
    check("redir_addr", 32'(ifu_rd_addr), 32'h300);
    for (int c = 0; c < 8; c++) begin
      observe();
      step();
    end
    check("redir_valid", 32'(instr_valid), 32'd1);
    check("redir_head",  32'(instr_pc),    32'h306);

    // Asynchronous reset while three words are queued
    do_reset();
    do_start(12'h040);
    repeat (4) begin
      observe();
      step();
    end
    check("pre_reset_valid", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    instr_ready = 1'b1;
    repeat (5) begin
      check("post_reset_req",   32'(ifu_rd_req),  32'd0);
      check("post_reset_valid", 32'(instr_valid), 32'd0);
      step();
    end

`ifdef PREFETCH_STATS_EN
    // 10 fetches across two redirects
    do_reset();
    check("stat_fetch_rst", 32'(stat_fetch_cnt), 32'd0);
    check("stat_flush_rst", 32'(stat_flush_cnt), 32'd0);
    do_start(12'h000);
    repeat (6) step();
    redirect    = 1'b1;
    redirect_pc = 12'h100;
    step();
    redirect    = 1'b0;
    step();
    repeat (4) step();
    redirect    = 1'b1;
    redirect_pc = 12'h200;
    step();
    redirect    = 1'b0;
    step();
    repeat (2) step();
    check("stat_fetch", 32'(stat_fetch_cnt), 32'd10);
    check("stat_flush", 32'(stat_flush_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
